hdmi_out_timing_gen: RTL

Video timing generator and pixel pump on the HDMI output path, sitting directly downstream of the HDMI-out pixel FIFO read port. It runs entirely in the FIFO read clock domain and produces HS/VS/DE and pixel data for the HDMI transmitter. It pops one FIFO word per active pixel and primes the FIFO to a fill threshold before starting a frame. Underflow is handled by emitting black and raising a sticky flag.

---
 rtl/hdmi_out_timing_gen.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/hdmi_out_timing_gen.sv
// rtl/hdmi_out_timing_gen.sv - video timing generator and pixel pump on the HDMI FIFO read side
module hdmi_out_timing_gen #(
  parameter int H_ACTIVE    = 1280,
  parameter int H_FP        = 110,
  parameter int H_SYNC      = 40,
  parameter int H_BP        = 220,
  parameter int V_ACTIVE    = 720,
  parameter int V_FP        = 5,
  parameter int V_SYNC      = 5,
  parameter int V_BP        = 20,
  parameter bit HS_POL      = 1'b1,
  parameter bit VS_POL      = 1'b1,
  parameter int DATA_WIDTH  = 24,
  parameter int DEPTH_WIDTH = 10,
  parameter int PRIME_LEVEL = 512
) (
  input  logic                   rd_clk,
  input  logic                   rd_rst,
  input  logic                   enable,
  output logic                   fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
  input  logic                   fifo_rd_empty,
  input  logic [DEPTH_WIDTH:0]   fifo_rd_water_level,
  output logic                   vid_hs,
  output logic                   vid_vs,
  output logic                   vid_de,
  output logic [DATA_WIDTH-1:0]  vid_data,
  output logic                   frame_start,
  output logic                   underflow,
  input  logic                   clear_underflow
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int LW = DEPTH_WIDTH + 1;

  // Constants are one bit wider than the counters so sync end points never alias.
  localparam logic [HW:0] H_ACT_C  = (HW+1)'(H_ACTIVE);
  localparam logic [HW:0] HS_BEG_C = (HW+1)'(H_ACTIVE + H_FP);
  localparam logic [HW:0] HS_END_C = (HW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW:0] H_LAST_C = (HW+1)'(H_TOTAL - 1);
  localparam logic [VW:0] V_ACT_C  = (VW+1)'(V_ACTIVE);
  localparam logic [VW:0] VS_BEG_C = (VW+1)'(V_ACTIVE + V_FP);
  localparam logic [VW:0] VS_END_C = (VW+1)'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW:0] V_LAST_C = (VW+1)'(V_TOTAL - 1);
  localparam logic [LW-1:0] PRIME_C = LW'(PRIME_LEVEL);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PRIME = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic          run, h_last, v_last, active, hs_raw, vs_raw, starve;

  logic de1_q, hs1_q, vs1_q, fs1_q, uf1_q;
  logic de2_q, hs2_q, vs2_q, fs2_q, uf_q, uf_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  assign run    = (state_q == ST_RUN);
  assign h_last = ({1'b0, h_cnt_q} == H_LAST_C);
  assign v_last = ({1'b0, v_cnt_q} == V_LAST_C);
  assign active = run && ({1'b0, h_cnt_q} < H_ACT_C) && ({1'b0, v_cnt_q} < V_ACT_C);
  assign starve = active && fifo_rd_empty;
  assign hs_raw = (run && ({1'b0, h_cnt_q} >= HS_BEG_C) && ({1'b0, h_cnt_q} < HS_END_C))
                  ? HS_POL : ~HS_POL;
  assign vs_raw = (run && ({1'b0, v_cnt_q} >= VS_BEG_C) && ({1'b0, v_cnt_q} < VS_END_C))
                  ? VS_POL : ~VS_POL;
  assign fifo_rd_en = active && !fifo_rd_empty;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (enable) state_d = ST_PRIME;
      ST_PRIME: begin
        if (!enable) state_d = ST_IDLE;
        else if (fifo_rd_water_level >= PRIME_C) state_d = ST_RUN;
      end
      ST_RUN:   if (h_last && v_last && !enable) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    h_cnt_d = '0;
    v_cnt_d = '0;
    if (run) begin
      if (h_last) begin
        v_cnt_d = v_last ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
      end
    end
  end

  // A starved pixel still goes out with de high, just black.
  assign data_d = (de1_q && !uf1_q) ? fifo_rd_data : '0;
  assign uf_d   = uf1_q | (uf_q & ~clear_underflow);

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state_q <= ST_IDLE;
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      de1_q   <= 1'b0;
      hs1_q   <= ~HS_POL;
      vs1_q   <= ~VS_POL;
      fs1_q   <= 1'b0;
      uf1_q   <= 1'b0;
      de2_q   <= 1'b0;
      hs2_q   <= ~HS_POL;
      vs2_q   <= ~VS_POL;
      fs2_q   <= 1'b0;
      data_q  <= '0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      de1_q   <= active;
      hs1_q   <= hs_raw;
      vs1_q   <= vs_raw;
      fs1_q   <= run && (h_cnt_q == '0) && (v_cnt_q == '0);
      uf1_q   <= starve;
      de2_q   <= de1_q;
      hs2_q   <= hs1_q;
      vs2_q   <= vs1_q;
      fs2_q   <= fs1_q;
      data_q  <= data_d;
      uf_q    <= uf_d;
    end
  end

  assign vid_hs      = hs2_q;
  assign vid_vs      = vs2_q;
  assign vid_de      = de2_q;
  assign vid_data    = data_q;
  assign frame_start = fs2_q;
  assign underflow   = uf_q;

endmodule
